mem_access_fsm: RTL and testbench

MEM_ACCESS_FSM -- requirements
Module: mem_access_fsm

---
 rtl/mem_access_fsm.sv | 192 +++++++++++++++++++
 tb/tb_mem_access_fsm.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_fsm.sv
// Purpose: single-outstanding load/store sequencer between the memory pipeline stage and a gnt/rvalid memory port.
// Latency: accept with immediate gnt at T, rvalid at T+1, done_o at T+2; bad ops report done_o/err_o one cycle after acceptance.
// Backpressure: stall_o holds upstream while an op is offered in IDLE or in flight (REQ/WAIT); memory throttles via mem_gnt_i and mem_rvalid_i.
module mem_access_fsm #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  state_t            state_q, state_d;
  logic [3:0]        op_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic              op_legal, misaligned, accept, reject;
  logic [3:0]        be_in;
  logic [31:0]       wdata_in;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_ext;

  // Decode the offered op: legality, alignment, byte lanes and lane-replicated store data.
  always_comb begin
    op_legal   = 1'b0;
    misaligned = 1'b0;
    be_in      = 4'b1111;
    wdata_in   = '0;
    case (mem_op_i)
      OP_LB, OP_LBU: op_legal = 1'b1;
      OP_LH, OP_LHU: begin
        op_legal   = 1'b1;
        misaligned = addr_i[0];
      end
      OP_LW: begin
        op_legal   = 1'b1;
        misaligned = |addr_i[1:0];
      end
      OP_SB: begin
        op_legal = 1'b1;
        be_in    = 4'b0001 << addr_i[1:0];
        wdata_in = {4{wdata_i[7:0]}};
      end
      OP_SH: begin
        op_legal   = 1'b1;
        misaligned = addr_i[0];
        be_in      = 4'b0011 << {addr_i[1], 1'b0};
        wdata_in   = {2{wdata_i[15:0]}};
      end
      OP_SW: begin
        op_legal   = 1'b1;
        misaligned = |addr_i[1:0];
        wdata_in   = wdata_i;
      end
      default: op_legal = 1'b0;
    endcase
  end

  assign accept = (state_q == IDLE) && valid_i && op_legal && !misaligned;
  assign reject = (state_q == IDLE) && valid_i && !(op_legal && !misaligned);

  // Pick the addressed byte/half of the returned word and extend it per the latched op.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rdata_i[7:0];
      2'd1:    ld_byte = mem_rdata_i[15:8];
      2'd2:    ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (op_q)
      OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_ext = {24'd0, ld_byte};
      OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_ext = {16'd0, ld_half};
      OP_LW:   ld_ext = mem_rdata_i;
      default: ld_ext = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and outputs; memory-port fields are zero whenever no request is presented.
  always_comb begin
    state_d     = state_q;
    stall_o     = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        stall_o = valid_i;
        if (accept) begin
          mem_req_o   = 1'b1;
          mem_we_o    = mem_op_i[3];
          mem_be_o    = be_in;
          mem_addr_o  = {addr_i[ADDR_W-1:2], 2'b00};
          mem_wdata_o = wdata_in;
          state_d     = mem_gnt_i ? WAIT : REQ;
        end else if (reject) begin
          state_d = DONE;
        end
      end
      REQ: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = op_q[3];
        mem_be_o    = be_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        if (mem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        stall_o = 1'b1;
        if (mem_rvalid_i) state_d = DONE;
      end
      default: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = IDLE;
      end
    endcase
  end

  // Capture the op on acceptance so upstream changes cannot disturb it; register the load result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q    <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (accept) begin
      op_q    <= mem_op_i;
      off_q   <= addr_i[1:0];
      addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
      be_q    <= be_in;
      wdata_q <= wdata_in;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (reject) begin
      err_q   <= 1'b1;
      rdata_q <= '0;
    end else if (state_q == WAIT && mem_rvalid_i) begin
      rdata_q <= ld_ext;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_access_fsm.sv
// Purpose: directed per-cycle vectors for mem_access_fsm, plus an asynchronous mid-cycle reset sequence.
// Latency: each vector drives inputs 1ns after a rising edge and samples outputs 2ns later.
// Backpressure: memory gnt/rvalid are scripted per vector.
module tb_mem_access_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [3:0]  op;
  logic [31:0] addr, wdata;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] maddr, mwdata;
  logic        gnt, rvalid;
  logic [31:0] mrdata;

  always #5 clk = ~clk;

  mem_access_fsm #(.ADDR_W(32)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .valid_i      (valid),
    .mem_op_i     (op),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .stall_o      (stall),
    .done_o       (done),
    .rdata_o      (rdata),
    .err_o        (err),
    .mem_req_o    (req),
    .mem_we_o     (we),
    .mem_be_o     (be),
    .mem_addr_o   (maddr),
    .mem_wdata_o  (mwdata),
    .mem_gnt_i    (gnt),
    .mem_rvalid_i (rvalid),
    .mem_rdata_i  (mrdata)
  );

  typedef struct {
    logic        r, vl;
    logic [3:0]  op;
    logic [31:0] a, wd;
    logic        g, rv;
    logic [31:0] mrd;
    logic        st, dn, er;
    logic [31:0] rd;
    logic        rq, we;
    logic [3:0]  be;
    logic [31:0] ma, mwd;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic r, input logic vl, input logic [3:0] o,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic g, input logic rv, input logic [31:0] mrd,
                              input logic st, input logic dn, input logic er, input logic [31:0] rd,
                              input logic rq, input logic w, input logic [3:0] b,
                              input logic [31:0] ma, input logic [31:0] mwd);
    vec_t t;
    t.r = r; t.vl = vl; t.op = o; t.a = a; t.wd = wd; t.g = g; t.rv = rv; t.mrd = mrd;
    t.st = st; t.dn = dn; t.er = er; t.rd = rd; t.rq = rq; t.we = w; t.be = b;
    t.ma = ma; t.mwd = mwd;
    return t;
  endfunction

  task automatic check(input int id, input vec_t t);
    n_vec++;
    if ({stall, done, err, rdata, req, we, be, maddr, mwdata} !==
        {t.st, t.dn, t.er, t.rd, t.rq, t.we, t.be, t.ma, t.mwd}) begin
      n_bad++;
      $display("FAIL vec%0d: got stall=%b done=%b err=%b rdata=%h req=%b we=%b be=%b addr=%h wdata=%h | want stall=%b done=%b err=%b rdata=%h req=%b we=%b be=%b addr=%h wdata=%h",
               id, stall, done, err, rdata, req, we, be, maddr, mwdata,
               t.st, t.dn, t.er, t.rd, t.rq, t.we, t.be, t.ma, t.mwd);
    end
  endtask

  task automatic apply(input vec_t t, input int id);
    @(posedge clk);
    #1;
    rst_n = t.r; valid = t.vl; op = t.op; addr = t.a; wdata = t.wd;
    gnt = t.g; rvalid = t.rv; mrdata = t.mrd;
    #2;
    check(id, t);
  endtask

  initial begin
    vec_t z;
    rst_n = 1'b0; valid = 1'b0; op = '0; addr = '0; wdata = '0;
    gnt = 1'b0; rvalid = 1'b0; mrdata = '0;
    z = mk(1,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0);

    // reset and idle
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0));
    vecs.push_back(z);
    // LB 0x1003, immediate gnt, rvalid next cycle, sign-extended byte
    vecs.push_back(mk(1,1,0,32'h1003,0,1,0,0, 1,0,0,0, 1,0,4'hF,32'h1000,0));
    vecs.push_back(mk(1,0,0,0,0,0,1,32'h80FF_FFFF, 1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0,32'hFFFF_FF80, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,32'hFFFF_FF80, 0,0,0,0,0));
    // SH 0x2002: replicated half, upper lanes; upstream changes in WAIT ignored
    vecs.push_back(mk(1,1,9,32'h2002,32'h0000_BEEF,1,0,0, 1,0,0,32'hFFFF_FF80, 1,1,4'hC,32'h2000,32'hBEEF_BEEF));
    vecs.push_back(mk(1,1,2,0,0,0,1,32'hDEAD_BEEF, 1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0,0, 0,0,0,0,0));
    vecs.push_back(z);
    // LHU 0x10, gnt withheld 3 cycles; spurious rvalid in REQ; gnt and valid in DONE ignored
    vecs.push_back(mk(1,1,5,32'h10,0,0,0,0, 1,0,0,0, 1,0,4'hF,32'h10,0));
    vecs.push_back(mk(1,0,0,0,0,0,1,32'hFFFF_FFFF, 1,0,0,0, 1,0,4'hF,32'h10,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,0, 1,0,4'hF,32'h10,0));
    vecs.push_back(mk(1,0,0,0,0,1,0,0, 1,0,0,0, 1,0,4'hF,32'h10,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,1,32'h1234_9ABC, 1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,1,0,0, 0,1,0,32'h0000_9ABC, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,32'h0000_9ABC, 0,0,0,0,0));
    // LW misaligned 0x6: no request, err with done, rdata cleared
    vecs.push_back(mk(1,1,2,32'h6,0,0,0,0, 1,0,0,32'h0000_9ABC, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,1,1,0, 0,0,0,0,0));
    vecs.push_back(z);
    // spurious rvalid in IDLE, then illegal op 0xF with gnt high
    vecs.push_back(mk(1,0,0,0,0,0,1,32'hFFFF_FFFF, 0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,1,4'hF,0,0,1,0,0, 1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,1,1,0, 0,0,0,0,0));
    vecs.push_back(z);
    // SW misaligned 0x101
    vecs.push_back(mk(1,1,4'hA,32'h101,0,1,0,0, 1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,1,1,0, 0,0,0,0,0));
    // SB 0x403 with gnt and rvalid together in the accept cycle: rvalid ignored
    vecs.push_back(mk(1,1,8,32'h403,32'h1234_56A5,1,1,32'h1111_1111, 1,0,0,0, 1,1,4'h8,32'h400,32'hA5A5_A5A5));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,1,0, 1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0,0, 0,0,0,0,0));
    // LH 0x22: upper half, sign-extended
    vecs.push_back(mk(1,1,1,32'h22,0,1,0,0, 1,0,0,0, 1,0,4'hF,32'h20,0));
    vecs.push_back(mk(1,0,0,0,0,0,1,32'h8001_7FFF, 1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0,32'hFFFF_8001, 0,0,0,0,0));
    // SW 0x30: data passes through, store result is zero
    vecs.push_back(mk(1,1,4'hA,32'h30,32'hCAFE_F00D,1,0,0, 1,0,0,32'hFFFF_8001, 1,1,4'hF,32'h30,32'hCAFE_F00D));
    vecs.push_back(mk(1,0,0,0,0,0,1,32'h5555_5555, 1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0,0, 0,0,0,0,0));
    // LBU 0x2: byte 2, zero-extended
    vecs.push_back(mk(1,1,4,32'h2,0,1,0,0, 1,0,0,0, 1,0,4'hF,32'h0,0));
    vecs.push_back(mk(1,0,0,0,0,0,1,32'h00C3_0000, 1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0,32'h0000_00C3, 0,0,0,0,0));
    // LW 0x44: whole word
    vecs.push_back(mk(1,1,2,32'h44,0,1,0,0, 1,0,0,32'h0000_00C3, 1,0,4'hF,32'h44,0));
    vecs.push_back(mk(1,0,0,0,0,0,1,32'h89AB_CDEF, 1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0,32'h89AB_CDEF, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,32'h89AB_CDEF, 0,0,0,0,0));
    // reset during REQ: gnt and late rvalid after release ignored
    vecs.push_back(mk(1,1,2,32'hC,0,0,0,0, 1,0,0,32'h89AB_CDEF, 1,0,4'hF,32'hC,0));
    vecs.push_back(mk(0,0,0,0,0,1,0,0, 0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,1,0,0, 0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,1,32'h1234_5678, 0,0,0,0, 0,0,0,0,0));
    // LW 0x8 accepted, leading into the WAIT reset sequence below
    vecs.push_back(mk(1,1,2,32'h8,0,1,0,0, 1,0,0,0, 1,0,4'hF,32'h8,0));

    foreach (vecs[i]) apply(vecs[i], i);

    // Reset asserted mid-cycle during WAIT: outputs clear without a clock edge.
    apply(mk(1,0,0,0,0,0,0,0, 1,0,0,0, 0,0,0,0,0), 900);
    #3 rst_n = 1'b0;
    #1 check(901, mk(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0));
    // Late response after release must not complete anything.
    apply(mk(1,0,0,0,0,0,1,32'hCAFE_CAFE, 0,0,0,0, 0,0,0,0,0), 902);
    apply(z, 903);
    apply(z, 904);
    // FSM still usable afterwards: LBU byte 1.
    apply(mk(1,1,4,32'h501,0,1,0,0, 1,0,0,0, 1,0,4'hF,32'h500,0), 905);
    apply(mk(1,0,0,0,0,0,1,32'h0000_F100, 1,0,0,0, 0,0,0,0,0), 906);
    apply(mk(1,0,0,0,0,0,0,0, 0,1,0,32'h0000_00F1, 0,0,0,0,0), 907);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
